// File: rtl/mdsa_loader.sv
// Frame loader and phase sequencer for an N x N mesh sort engine (MDSA).
// Optional snake-order row directions are enabled with the MDSA_SNAKE_DIR_EN macro.
module mdsa_loader #(
    parameter int N            = 8,
    parameter int DW           = 32,
    parameter int PHASES       = 3,
    parameter int PHASE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    output logic [N*N*DW-1:0] data_in_new,
    output logic              en,
    output logic              start,
    output logic              trans,
    output logic [N-1:0]      dir,
    output logic              busy,
    output logic              done
);

    localparam int CW  = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int PCW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CW-1:0]  CNT_LAST = CW'(N * N - 1);
    localparam logic [PCW-1:0] PC_LAST  = PCW'(PHASE_CYCLES - 1);
    localparam logic [3:0]     PH_LAST  = 4'(PHASES - 1);

`ifdef MDSA_SNAKE_DIR_EN
    function automatic logic [N-1:0] snake_mask();
        logic [N-1:0] m;
        for (int r = 0; r < N; r++) begin
            m[r] = (r % 2) != 0;
        end
        return m;
    endfunction

    localparam logic [N-1:0] SNAKE = snake_mask();
`endif

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sub_q, sub_d;
    logic [PCW-1:0]   pcyc_q, pcyc_d;
    logic [3:0]       phase_q, phase_d;
    logic [N*N*DW-1:0] buf_q, buf_d;

    logic             s_ready_q, s_ready_d;
    logic             en_q, en_d;
    logic             start_q, start_d;
    logic             trans_q, trans_d;
    logic [N-1:0]     dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             xfer;

    assign xfer = s_valid && s_ready_q && (state_q == ST_LOAD);

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        pcyc_d  = pcyc_q;
        phase_d = phase_q;
        buf_d   = buf_q;
        case (state_q)
            ST_LOAD: begin
                if (xfer) begin
                    buf_d[int'(cnt_q)*DW +: DW] = s_data;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        sub_d   = 1'b0;
                        state_d = ST_START;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_START: begin
                if (!sub_q) begin
                    sub_d = 1'b1;
                end else begin
                    sub_d   = 1'b0;
                    pcyc_d  = '0;
                    phase_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pcyc_q == PC_LAST) begin
                    pcyc_d = '0;
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end else begin
                    pcyc_d = pcyc_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q after the edge
    always_comb begin
        s_ready_d = (state_d == ST_LOAD);
        busy_d    = (state_d == ST_START) || (state_d == ST_RUN);
        en_d      = busy_d;
        start_d   = (state_d == ST_START);
        done_d    = (state_d == ST_DONE);
        trans_d   = ((state_d == ST_START) && sub_d) ||
                    ((state_d == ST_RUN) && (pcyc_d == PC_LAST));
        dir_d     = '0;
`ifdef MDSA_SNAKE_DIR_EN
        if (busy_d && !phase_d[0]) begin
            dir_d = SNAKE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_LOAD;
            cnt_q     <= '0;
            sub_q     <= 1'b0;
            pcyc_q    <= '0;
            phase_q   <= '0;
            buf_q     <= '0;
            s_ready_q <= 1'b0;
            en_q      <= 1'b0;
            start_q   <= 1'b0;
            trans_q   <= 1'b0;
            dir_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            pcyc_q    <= pcyc_d;
            phase_q   <= phase_d;
            buf_q     <= buf_d;
            s_ready_q <= s_ready_d;
            en_q      <= en_d;
            start_q   <= start_d;
            trans_q   <= trans_d;
            dir_q     <= dir_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign data_in_new = buf_q;
    assign en          = en_q;
    assign start       = start_q;
    assign trans       = trans_q;
    assign dir         = dir_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mdsa_loader.sv
// Directed bench for mdsa_loader: frame loading, phase sequencing, reset abort and dir pattern.
// Expected per-cycle control outputs come from an independent timeline model.
module tb_mdsa_loader;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int P  = 3;
    localparam int PC = 8;
    localparam int RUN_END = 2 + P * PC - 1;

    logic              clk;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic [N*N*DW-1:0] data_in_new;
    logic              en;
    logic              start;
    logic              trans;
    logic [N-1:0]      dir;
    logic              busy;
    logic              done;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [DW-1:0] sb[$];

    mdsa_loader #(.N(N), .DW(DW), .PHASES(P), .PHASE_CYCLES(PC)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .data_in_new(data_in_new), .en(en), .start(start), .trans(trans), .dir(dir),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] out_vec();
        return {s_ready, en, start, trans, busy, done, dir};
    endfunction

    task automatic load_frame(input logic [DW-1:0] base, input bit toggle);
        int acc = 0;
        int cyc = 0;
        bit ph = 1'b1;
        bit xfer;
        while (acc < N * N && cyc < 400) begin
            s_valid = toggle ? ph : 1'b1;
            ph      = ~ph;
            s_data  = base + DW'(acc);
            xfer    = s_valid && s_ready;
            if (xfer) sb.push_back(s_data);
            tick();
            if (xfer) acc++;
            cyc++;
        end
        s_valid = 1'b0;
        check("load_count", 64'(acc), 64'(N * N));
        check("start_after_last", 64'({s_ready, en, start, trans, busy}), 64'(5'b01101));
    endtask

    task automatic check_frame();
        logic [DW-1:0] e;
        for (int k = 0; k < N * N; k++) begin
            if (sb.size() == 0) begin
                check("sb_empty", 64'(k), 64'(N * N));
                break;
            end
            e = sb.pop_front();
            check($sformatf("slot%0d", k), 64'(data_in_new[k*DW +: DW]), 64'(e));
        end
    endtask

    function automatic logic [13:0] exp_vec(input int c);
        logic b, st, tr, dn;
        logic [N-1:0] d;
        int ph;
        b  = (c <= RUN_END);
        st = (c < 2);
        tr = (c == 1) || (c >= 2 && c <= RUN_END && ((c - 2) % PC) == PC - 1);
        dn = (c == RUN_END + 1);
        ph = (c < 2) ? 0 : (c - 2) / PC;
        d  = '0;
`ifdef MDSA_SNAKE_DIR_EN
        if (b && (ph % 2) == 0) d = 8'hAA;
`endif
        return {1'b0, b, st, tr, b, dn, d};
    endfunction

    // Walk START/RUN/DONE with s_valid held high and garbage data on the bus.
    task automatic run_frame();
        logic [N*N*DW-1:0] snap;
        snap = data_in_new;
        for (int c = 0; c <= RUN_END + 1; c++) begin
            check($sformatf("ctl_c%0d", c), 64'(out_vec()), 64'(exp_vec(c)));
            s_valid = 1'b1;
            s_data  = $urandom;
            tick();
        end
        s_valid = 1'b0;
        check("back_to_load", 64'(out_vec()), 64'(14'b10000000000000));
        check("buf_stable", 64'(data_in_new == snap), 64'(1));
    endtask

    initial begin
        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        #12;
        check("reset_outputs", 64'(out_vec()), 64'(0));
        check("reset_buf", 64'(data_in_new == '0), 64'(1));
        #1 rst = 1'b1;
        tick();
        check("ready_after_reset", 64'(out_vec()), 64'(14'b10000000000000));

        // Frame 1: back-to-back words 0..63
        load_frame(32'd0, 1'b0);
        check("first_elem", 64'(data_in_new[31:0]), 64'(0));
        check("last_elem", 64'(data_in_new[2047:2016]), 64'(63));
        check_frame();
        run_frame();

        // Frame 2: s_valid toggling
        load_frame(32'd1000, 1'b1);
        check_frame();
        run_frame();

        // Frame 3: reset during RUN phase 1
        load_frame(32'd5000, 1'b0);
        check_frame();
        for (int c = 0; c < 2 + PC + 3; c++) tick();
        check("in_phase1", 64'({busy, start}), 64'(2'b10));
        #2 rst = 1'b0;
        #1;
        check("abort_outputs", 64'(out_vec()), 64'(0));
        check("abort_buf", 64'(data_in_new == '0), 64'(1));
        #3 rst = 1'b1;
        tick();
        check("abort_ready", 64'(out_vec()), 64'(14'b10000000000000));
        s_valid = 1'b1;
        s_data  = 32'h1234_5678;
        tick();
        s_valid = 1'b0;
        check("cnt_restart_slot0", 64'(data_in_new[31:0]), 64'(32'h1234_5678));
        check("cnt_restart_slot1", 64'(data_in_new[63:32]), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mdsa_loader.md
MDSA_LOADER -- requirements
Module: mdsa_loader

Interface
REQ-001 SHALL have parameter N, default 8, matrix side (rows = columns = N).
REQ-002 SHALL have parameter DW, default 32, element width in bits.
REQ-003 SHALL have parameter PHASES, default 3, number of sort phases per frame (1..15).
REQ-004 SHALL have parameter PHASE_CYCLES, default 8, clk cycles per phase, at least 2 and at least the downstream sorter pipeline latency.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous assert, active-low.
REQ-007 SHALL have port s_valid, input, 1, upstream word valid.
REQ-008 SHALL have port s_ready, output, 1, loader accepts a word.
REQ-009 SHALL have port s_data, input, DW, element word.
REQ-010 SHALL have port data_in_new, output, N*N*DW, assembled frame; element k occupies bits [k*DW +: DW].
REQ-011 SHALL have port en, output, 1, sorter enable.
REQ-012 SHALL have port start, output, 1, selects data_in_new into the sorter register.
REQ-013 SHALL have port trans, output, 1, sorter register capture strobe.
REQ-014 SHALL have port dir, output, N, per-row sort direction.
REQ-015 SHALL have port busy, output, 1, high in START and RUN.
REQ-016 SHALL have port done, output, 1, one-cycle frame-complete pulse.

Function
REQ-017 SHALL implement the FSM states LOAD, START, RUN and DONE; all outputs are registered.
REQ-018 SHALL hold s_ready=1 only in LOAD; a word transfers when s_valid and s_ready are both high.
REQ-019 SHALL write the word with index cnt to slot cnt and increment cnt, where cnt is a 0..N*N-1 counter.
REQ-020 SHALL, on the transfer of word N*N-1, clear cnt to 0 and enter START.
REQ-021 SHALL ignore s_valid outside LOAD, with no buffer write.
REQ-022 SHALL hold START for 2 cycles with en=1 and start=1: trans=0 in cycle 1 and trans=1 in cycle 2; then enter RUN with phase=0.
REQ-023 SHALL, in RUN, drive en=1 and start=0 and count pcyc from 0 to PHASE_CYCLES-1; trans=1 only when pcyc=PHASE_CYCLES-1.
REQ-024 SHALL, at the end of each phase, increment phase; after phase PHASES-1 ends, enter DONE.
REQ-025 SHALL keep trans high for exactly one cycle per pulse, with at least one low cycle between pulses.
REQ-026 SHALL, in DONE, drive done=1, en=0, start=0 and trans=0 for one cycle, then return to LOAD.
REQ-027 SHALL hold data_in_new stable outside LOAD, so the sorter keeps the sorted frame while en=0.
REQ-028 SHALL drive dir per the REQ-032 rule in START and RUN, and all-zero otherwise.

Reset
REQ-029 SHALL, while rst=0, asynchronously set state to LOAD, cnt, pcyc and phase to 0, and the buffer to 0.
REQ-030 SHALL, while rst=0, drive s_ready=0, en=0, start=0, trans=0, dir=0, busy=0 and done=0.
REQ-031 SHALL, on a reset in the middle of a frame, abandon the frame; the first cycle after release is LOAD with s_ready=1.

Configuration
REQ-032 SHALL use macro MDSA_SNAKE_DIR_EN: when defined, even phases drive dir bit r = r mod 2 (snake order) and odd phases drive dir=0; when undefined, dir=0 in all phases.

Verification
REQ-033 SHALL cover: 64 back-to-back words 0..63 -> data_in_new[31:0]=0 and [2047:2016]=63; START entered on the cycle after word 63.
REQ-034 SHALL cover: s_valid toggling 1/0 each cycle -> exactly 64 accepted, cnt never skips, START after the 64th transfer.
REQ-035 SHALL cover: PHASES=3 and PHASE_CYCLES=8 -> 4 trans pulses in total (1 in START, 3 in RUN) spaced 8 cycles apart in RUN; done 1 cycle after the last.
REQ-036 SHALL cover: rst pulled low at RUN phase 1 -> all outputs 0 immediately; after release s_ready=1 and cnt=0.
REQ-037 SHALL cover: MDSA_SNAKE_DIR_EN defined, N=8 -> dir=8'hAA in phases 0 and 2 and 8'h00 in phase 1; undefined -> 8'h00 throughout.
REQ-038 SHALL cover: s_valid=1 held during START and RUN -> s_ready=0 and buffer unchanged.
